// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller.
// Holds the fetch state encoding, the NOP instruction word, the default
// reset PC and exception vector, and a small alignment helper.
// The optional misaligned-target check is enabled by the macro
// FETCH_ALIGN_CHECK_EN (see fetch_pc_ctrl.sv).
package fetch_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetchState_e;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;

  // A fetch address is word aligned only when its two low bits are zero.
  function automatic logic isMisaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   load_i            capture instr_i/pc4_i and mark the entry live
//   clear_i           drop the entry (bubble or flush): valid=0, instr=NOP
//   instr_i, pc4_i    instruction word and its PC+4
//   valid_o           entry holds a live instruction
//   instr_o, pc4_o    registered instruction and PC+4
// With neither load_i nor clear_i the contents are held (stall).
module if_id_reg
  import fetch_pc_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;

  // Clear wins over load so a flush can never let a stale word through.
  // A cleared entry always shows NOP so downstream decode sees a harmless
  // instruction whenever valid is low. PC+4 is left alone on clear because
  // it is only meaningful alongside a live instruction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC register and next-PC control.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   stall                    hazard unit hold of IF/ID and PC
//   branch_taken/_target     ID-stage taken branch and its destination
//   jump/jump_target         ID-stage jump and its destination
//   pc_plus4                 PC+4 from the external incrementer
//   pc                       current PC (incrementer input, imem address)
//   imem_req/ack/rdata       instruction memory handshake
//   if_valid/instr/pc4       IF/ID pipeline register outputs
//   addr_err                 one-cycle pulse on a misaligned redirect
// Optional feature macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets
// are replaced by EXC_VECTOR and flagged on addr_err. Without it targets
// are used verbatim and addr_err stays 0.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] pc_plus4,
  output logic [31:0] pc,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        addr_err
);

  fetchState_e state_q;
  logic [31:0] pc_q;
  logic        imemReq_q;
  logic        addrErr_q;
  logic [31:0] skidInstr_q;
  logic [31:0] skidPc4_q;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] redirectPc;
  logic        misaligned;
  logic        loadIfId;
  logic        clearIfId;
  logic [31:0] ifIdInstr;
  logic [31:0] ifIdPc4;

  // Pick the redirect source: jump beats a taken branch.
  always_comb begin
    redirect = jump | branch_taken;
    target   = jump ? jump_target : branch_target;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Misaligned destinations are steered to the exception vector.
  assign misaligned = redirect && isMisaligned(target);
  assign redirectPc = misaligned ? EXC_VECTOR : target;
`else
  logic unusedExcVector;
  assign unusedExcVector = ^EXC_VECTOR;
  assign misaligned      = 1'b0;
  assign redirectPc      = target;
`endif

  // IF/ID control. A redirect flushes regardless of stall and any ack in
  // that cycle is dropped. Otherwise IF/ID loads either the live imem word
  // (REQ with ack) or the skid buffer (HOLD), but only when not stalled.
  // A REQ cycle without ack and without stall inserts a bubble.
  always_comb begin
    loadIfId  = 1'b0;
    clearIfId = 1'b0;
    ifIdInstr = imem_rdata;
    ifIdPc4   = pc_plus4;
    if (redirect) begin
      clearIfId = 1'b1;
    end else if (!stall) begin
      if (state_q == REQ) begin
        loadIfId  = imem_ack;
        clearIfId = !imem_ack;
      end else if (state_q == HOLD) begin
        loadIfId  = 1'b1;
        ifIdInstr = skidInstr_q;
        ifIdPc4   = skidPc4_q;
      end
    end
  end

  // Fetch FSM with registered PC, request and error outputs. A stalled ack
  // parks the word and its PC+4 in the skid buffer and drops the request
  // until the stall releases; the parked PC+4 then becomes the new PC. A
  // redirect from any state restarts fetching at the target and discards
  // whatever the skid buffer held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      imemReq_q   <= 1'b0;
      addrErr_q   <= 1'b0;
      skidInstr_q <= NOP_INSTR;
      skidPc4_q   <= 32'h0;
    end else begin
      addrErr_q <= misaligned;
      if (redirect) begin
        state_q     <= REQ;
        pc_q        <= redirectPc;
        imemReq_q   <= 1'b1;
        skidInstr_q <= NOP_INSTR;
        skidPc4_q   <= 32'h0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q   <= REQ;
            imemReq_q <= 1'b1;
          end
          REQ: begin
            if (imem_ack) begin
              if (stall) begin
                state_q     <= HOLD;
                imemReq_q   <= 1'b0;
                skidInstr_q <= imem_rdata;
                skidPc4_q   <= pc_plus4;
              end else begin
                pc_q <= pc_plus4;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              state_q   <= REQ;
              imemReq_q <= 1'b1;
              pc_q      <= skidPc4_q;
            end
          end
          default: begin
            state_q   <= IDLE;
            imemReq_q <= 1'b0;
          end
        endcase
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (loadIfId),
    .clear_i (clearIfId),
    .instr_i (ifIdInstr),
    .pc4_i   (ifIdPc4),
    .valid_o (if_valid),
    .instr_o (if_instr),
    .pc4_o   (if_pc4)
  );

  assign pc       = pc_q;
  assign imem_req = imemReq_q;
  assign addr_err = addrErr_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Testbench for fetch_pc_ctrl: directed scenarios followed by randomized
// traffic, checked against a transaction-level reference model. Delivered
// instructions go through a scoreboard queue drained by a monitor process.
module tb_fetch_pc_ctrl;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetchItem_t;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc_plus4;
  logic [31:0] pc;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        addr_err;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model: the PC, whether fetching has started since reset,
  // an optional parked word, and the expected IF/ID valid / addr_err.
  logic [31:0] mPc;
  logic        mStarted;
  logic        mValid;
  logic        mAddrErr;
  fetchItem_t  bufQ[$];
  fetchItem_t  expQ[$];

  logic        stallAtEdge;
  fetchItem_t  monItem;

  fetch_pc_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc_plus4      (pc_plus4),
    .pc            (pc),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc4        (if_pc4),
    .addr_err      (addr_err)
  );

  // External PC incrementer.
  assign pc_plus4 = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs the DUT
  // sampled at that edge.
  task automatic modelStep();
    fetchItem_t item;
    logic [31:0] tgt;
    mAddrErr = 1'b0;
    if (rst) begin
      mPc      = 32'h0;
      mStarted = 1'b0;
      mValid   = 1'b0;
      bufQ.delete();
    end else if (jump || branch_taken) begin
      tgt = jump ? jump_target : branch_target;
      if (ALIGN_EN && tgt[1:0] != 2'b00) begin
        mPc      = 32'h180;
        mAddrErr = 1'b1;
      end else begin
        mPc = tgt;
      end
      mValid   = 1'b0;
      mStarted = 1'b1;
      bufQ.delete();
    end else if (!mStarted) begin
      mStarted = 1'b1;
    end else if (bufQ.size() != 0) begin
      if (!stall) begin
        item   = bufQ.pop_front();
        mPc    = item.pc4;
        mValid = 1'b1;
        expQ.push_back(item);
      end
    end else if (imem_ack) begin
      item.instr = imem_rdata;
      item.pc4   = mPc + 32'd4;
      if (stall) begin
        bufQ.push_back(item);
      end else begin
        mPc    = item.pc4;
        mValid = 1'b1;
        expQ.push_back(item);
      end
    end else if (!stall) begin
      mValid = 1'b0;
    end
  endtask

  task automatic checkOutput();
    logic expReq;
    expReq = mStarted && (bufQ.size() == 0);
    checkValue("pc", pc, mPc);
    checkValue("imem_req", 32'(imem_req), 32'(expReq));
    checkValue("if_valid", 32'(if_valid), 32'(mValid));
    checkValue("addr_err", 32'(addr_err), 32'(mAddrErr));
    if (!mValid) checkValue("if_instr_nop", if_instr, 32'h0);
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt,
                               input logic a, input logic [31:0] d);
    @(negedge clk);
    rst           = 1'b0;
    stall         = s;
    branch_taken  = b;
    branch_target = bt;
    jump          = j;
    jump_target   = jt;
    imem_ack      = a;
    imem_rdata    = d;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyReset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst          = 1'b1;
      stall        = 1'b0;
      branch_taken = 1'b0;
      jump         = 1'b0;
      imem_ack     = 1'b1;
      imem_rdata   = $urandom;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
    end
  endtask

  task automatic seqCycle(input logic s, input logic a);
    applyStimulus(s, 1'b0, 32'h0, 1'b0, 32'h0, a, $urandom);
  endtask

  function automatic logic [31:0] randTarget();
    logic [31:0] r;
    r = $urandom;
    r[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
    return r;
  endfunction

  // Monitor: IF/ID presents a new instruction whenever it is valid after an
  // edge at which the pipeline was not stalled.
  always @(posedge clk) begin
    stallAtEdge = stall;
    #1;
    if (if_valid && !stallAtEdge) begin
      if (expQ.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpected_instr: got %h expected none", if_instr);
      end else begin
        monItem = expQ.pop_front();
        checkValue("if_instr", if_instr, monItem.instr);
        checkValue("if_pc4", if_pc4, monItem.pc4);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;

    applyReset();
    checkValue("reset_pc", pc, 32'h0);
    checkValue("reset_req", 32'(imem_req), 32'h0);

    // Sequential fetch, then a stall on the acked fetch at pc=8.
    seqCycle(1'b0, 1'b1);
    seqCycle(1'b0, 1'b1);
    seqCycle(1'b0, 1'b1);
    checkValue("seq_pc8", pc, 32'h8);
    seqCycle(1'b1, 1'b1);
    seqCycle(1'b1, 1'b0);
    seqCycle(1'b1, 1'b1);
    checkValue("hold_pc", pc, 32'h8);
    checkValue("hold_req", 32'(imem_req), 32'h0);
    seqCycle(1'b0, 1'b0);
    checkValue("release_pc", pc, 32'hC);

    // Taken branch with a simultaneous ack.
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, $urandom);
    checkValue("branch_pc", pc, 32'h40);
    checkValue("branch_valid", 32'(if_valid), 32'h0);

    // Jump and branch together under stall.
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, $urandom);
    checkValue("jump_pc", pc, 32'h100);

    // Ack withheld.
    for (int i = 0; i < 4; i++) seqCycle(1'b0, 1'b0);
    checkValue("noack_pc", pc, 32'h100);
    checkValue("noack_req", 32'(imem_req), 32'h1);

    // PC wrap.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    seqCycle(1'b0, 1'b1);
    checkValue("wrap_pc", pc, 32'h0);

    // Misaligned jump target.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b1, $urandom);
    checkValue("misalign_pc", pc, ALIGN_EN ? 32'h180 : 32'h102);
    checkValue("misalign_err", 32'(addr_err), ALIGN_EN ? 32'h1 : 32'h0);
    seqCycle(1'b0, 1'b1);

    // Randomized traffic with a reset in the middle.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) applyReset();
      applyStimulus($urandom_range(0, 3) == 0,
                    $urandom_range(0, 11) == 0, randTarget(),
                    $urandom_range(0, 19) == 0, randTarget(),
                    $urandom_range(0, 9) < 7, $urandom);
    end

    for (int i = 0; i < 4; i++) seqCycle(1'b0, 1'b0);
    #3;
    checkValue("scoreboard_drained", 32'(expQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
